// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the pipeline-boundary register: default widths,
// ID/EX control bit positions and the {S.valid, M.valid} state encoding.
package pipe_stage_skid_pkg;

   localparam int unsigned DEF_CTRL_W = 8;
   localparam int unsigned DEF_DATA_W = 111;
   localparam int unsigned DEF_CNT_W  = 16;

   // ID/EX control vector bit positions
   localparam int unsigned CTRL_REGWRITE = 7;
   localparam int unsigned CTRL_MEMTOREG = 6;
   localparam int unsigned CTRL_MEMREAD  = 5;
   localparam int unsigned CTRL_MEMWRITE = 4;
   localparam int unsigned CTRL_ALUSRC   = 3;
   localparam int unsigned CTRL_ALUOP_HI = 2;
   localparam int unsigned CTRL_ALUOP_LO = 1;
   localparam int unsigned CTRL_REGDST   = 0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_BAD   = 2'b10,
      ST_FULL  = 2'b11
   } state_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// One valid/ready link carrying a control vector and a data vector.
// master = producer side, slave = consumer side.
interface pipe_stage_skid_if
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned CTRL_W = DEF_CTRL_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (output valid, output ctrl, output data, input  ready);
   modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One storage entry (valid + ctrl + data). clr_ctrl wins over load and
// squashes the entry to a bubble while leaving the data register untouched.
module pipe_stage_skid_slot
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned CTRL_W = DEF_CTRL_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr_ctrl,
   input  logic [CTRL_W-1:0] src_ctrl,
   input  logic [DATA_W-1:0] src_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (clr_ctrl) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= src_ctrl;
         data  <= src_data;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with a 2-entry skid buffer, synchronous flush
// to bubbles and a saturating downstream-stall counter.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned CTRL_W = DEF_CTRL_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   pipe_stage_skid_if.slave  up,
   pipe_stage_skid_if.master dn,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              m_valid, s_valid;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl;
   logic [DATA_W-1:0] m_data, s_data;

   logic              m_load, m_clr, m_from_skid;
   logic              s_load, s_clr;
   logic [CTRL_W-1:0] m_src_ctrl;
   logic [DATA_W-1:0] m_src_data;
   logic              in_fire, out_fire;
   state_t            state;

   // State lives in the slot valid bits; ready is a pure register decode.
   assign state    = state_t'({s_valid, m_valid});
   assign up.ready = ~s_valid;
   assign dn.valid = m_valid;
   assign dn.ctrl  = m_ctrl;
   assign dn.data  = m_data;
   assign in_fire  = up.valid & up.ready;
   assign out_fire = m_valid & dn.ready;

   // Next-state / slot control; flush squashes both slots and drops in_fire.
   always_comb begin
      m_load      = 1'b0;
      m_clr       = 1'b0;
      m_from_skid = 1'b0;
      s_load      = 1'b0;
      s_clr       = 1'b0;
      if (flush) begin
         m_clr = 1'b1;
         s_clr = 1'b1;
      end else begin
         unique case (state)
            ST_EMPTY: m_load = in_fire;
            ST_ONE: begin
               if (in_fire && out_fire) m_load = 1'b1;
               else if (in_fire)        s_load = 1'b1;
               else if (out_fire)       m_clr  = 1'b1;
            end
            ST_FULL: begin
               if (out_fire) begin
                  m_load      = 1'b1;
                  m_from_skid = 1'b1;
                  s_clr       = 1'b1;
               end
            end
            default: begin
               m_clr = 1'b1;
               s_clr = 1'b1;
            end
         endcase
      end
   end

   assign m_src_ctrl = m_from_skid ? s_ctrl : up.ctrl;
   assign m_src_data = m_from_skid ? s_data : up.data;

   pipe_stage_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk      (clk),
      .rst      (rst),
      .load     (m_load),
      .clr_ctrl (m_clr),
      .src_ctrl (m_src_ctrl),
      .src_data (m_src_data),
      .valid    (m_valid),
      .ctrl     (m_ctrl),
      .data     (m_data)
   );

   pipe_stage_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (s_load),
      .clr_ctrl (s_clr),
      .src_ctrl (up.ctrl),
      .src_data (up.data),
      .valid    (s_valid),
      .ctrl     (s_ctrl),
      .data     (s_data)
   );

   // Saturating count of edges where the head is held by downstream.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (m_valid && !dn.ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
